range_sum_driver: RTL and testbench
===================================

# range_sum_driver

Sequential front-end that owns the eight 4-bit operand registers and drives the combinational range-sum adder's operand bus, clear line and range-control word. It accepts operand writes and range queries through valid/ready handshakes, holds the adder inputs stable for a programmable settle time, and captures the adder's 8-bit sum as a result pulse. An optional serial accumulator independently recomputes each range sum and flags any disagreement with the adder.

## Interface
Parameters:
- SETTLE_CYCLES, 2: cycles the adder inputs are held before capture; legal range 1..15.

Ports:
- CLK100MHZ  in  1  system clock, rising edge.
- BTNU  in  1  asynchronous active-high reset.
- wr_valid  in  1  operand write request.
- wr_ready  out  1  high in IDLE only.
- wr_addr  in  3  nibble index 0..7.
- wr_data  in  4  nibble value.
- q_valid  in  1  range query request.
- q_ready  out  1  high in IDLE only.
- q_hi  in  3  first range index; driven to contr_out[5:3].
- q_lo  in  3  second range index; driven to contr_out[2:0].
- I_out  out  32  operand bus to adder; nibble k at [4k+3:4k].
- contr_out  out  6  range control to adder, {q_hi,q_lo}.
- clr_out  out  1  adder clear; 1 in IDLE, 0 while a query is in flight.
- sum_in  in  8  adder sum, combinational from I_out/contr_out/clr_out.
- res_valid  out  1  one-cycle result strobe.
- res_data  out  8  captured sum; held until the next res_valid.
- mismatch  out  1  checker disagreement, valid with res_valid and held alongside res_data.

## Operation
- States: IDLE, SETTLE, CAPTURE.
- IDLE: wr_ready = q_ready = 1, clr_out = 1.
- Write: wr_valid in IDLE writes wr_data to operand register wr_addr at that edge. I_out always equals the operand register file.
- Query: accepted on q_valid in IDLE. contr_out latches {q_hi,q_lo}, clr_out drops, and the FSM enters SETTLE with settle counter = 0.
- Simultaneous write and query in IDLE: both are accepted; the write lands at the same edge and is included in the query.
- SETTLE: the counter increments each cycle. Exit to CAPTURE when the counter reaches SETTLE_CYCLES-1 and the checker is done.
- CAPTURE, one cycle:
  - res_data ← sum_in; res_valid = 1; mismatch ← (sum_in ≠ acc).
  - Next state IDLE; clr_out returns to 1.
- Range semantics match the adder:
  - lo = min(q_hi,q_lo), hi = max(q_hi,q_lo); the sum covers nibbles lo..hi inclusive.
  - q_hi = q_lo selects that single nibble.
- Widths: the 8-bit sum cannot overflow (maximum 8×15 = 120). Zero-extend nibbles before adding.
- wr_valid and q_valid outside IDLE are ignored, with no queuing. Requesters must hold valid until ready.

## Timing
- Reset values: state IDLE, all operand registers 0, I_out 0, contr_out 0, clr_out 1, res_valid 0, res_data 0, mismatch 0, wr_ready 1, q_ready 1.
- Query accept edge = cycle 0.
  - With the checker: res_valid is high in cycle max(SETTLE_CYCLES, hi-lo+1)+1.
  - Without the checker: res_valid is high in cycle SETTLE_CYCLES+1.
- q_ready returns high in the cycle after res_valid, so queries can issue back-to-back with one idle cycle between them.
- Checker: acc clears at accept. acc adds nibble k for k = lo..hi, one per cycle, starting in cycle 1, and signals done after the nibble at index hi.
- Reset mid-query: abort immediately with no res_valid. Operand registers return to 0.

## Configuration
- RANGE_SELFCHECK_EN defined: the serial checker is instantiated, mismatch is live, and latency follows the checker rule above.
- RANGE_SELFCHECK_EN undefined: no checker logic; mismatch is tied 0; CAPTURE follows SETTLE_CYCLES alone.

## Structure
- Package range_sum_pkg holds:
  - constants NIB_W = 4, NUM_NIB = 8, IDX_W = 3, SUM_W = 8;
  - the state enumeration {IDLE, SETTLE, CAPTURE}.
- Sub-module serial_range_acc contains the checker's index counter, accumulator and done flag. It is instantiated only under RANGE_SELFCHECK_EN.

## Test plan
- Reset, then write nibbles 0..7 = 1,2,3,4,5,6,7,8; query q_hi = 2, q_lo = 5 → res_data = 18, mismatch = 0. With the checker and SETTLE_CYCLES = 2, res_valid occurs in cycle 5.
- Same operands; query q_hi = 6, q_lo = 1 (reversed order) → res_data = 27.
- Query q_hi = q_lo = 7 → res_data = 8; all operands = 15 with a 0..7 query → res_data = 120.
- Stub the adder to return its true sum + 1 → mismatch = 1 with the checker, 0 without it.
- Assert wr_valid during SETTLE → operand register unchanged and wr_ready = 0. Write and query in the same IDLE cycle → result includes the new nibble.
- Assert BTNU in cycle 1 of a query → no res_valid, all outputs at reset values, q_ready = 1 after release.

Source files
------------

// File: rtl/range_sum_pkg.sv
// Shared widths and FSM encoding for the range-sum adder front-end.
package range_sum_pkg;

  localparam int NIB_W   = 4;
  localparam int NUM_NIB = 8;
  localparam int IDX_W   = 3;
  localparam int SUM_W   = 8;
  localparam int BUS_W   = NUM_NIB * NIB_W;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CAPTURE
  } state_e;

  function automatic logic [SUM_W-1:0] zext_nib(input logic [NIB_W-1:0] nib);
    return {{(SUM_W - NIB_W){1'b0}}, nib};
  endfunction

endpackage

// File: rtl/range_sum_driver_if.sv
// Request/result handshakes plus the adder-facing bus of range_sum_driver.
// The master side is the requester together with the combinational adder.
interface range_sum_driver_if;
  import range_sum_pkg::*;

  logic                   wr_valid;
  logic                   wr_ready;
  logic [IDX_W-1:0]       wr_addr;
  logic [NIB_W-1:0]       wr_data;
  logic                   q_valid;
  logic                   q_ready;
  logic [IDX_W-1:0]       q_hi;
  logic [IDX_W-1:0]       q_lo;
  logic [BUS_W-1:0]       I_out;
  logic [2*IDX_W-1:0]     contr_out;
  logic                   clr_out;
  logic [SUM_W-1:0]       sum_in;
  logic                   res_valid;
  logic [SUM_W-1:0]       res_data;
  logic                   mismatch;

  modport master (
    output wr_valid, wr_addr, wr_data, q_valid, q_hi, q_lo, sum_in,
    input  wr_ready, q_ready, I_out, contr_out, clr_out, res_valid, res_data, mismatch
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, q_valid, q_hi, q_lo, sum_in,
    output wr_ready, q_ready, I_out, contr_out, clr_out, res_valid, res_data, mismatch
  );

endinterface

// File: rtl/serial_range_acc.sv
// Serial checker: re-adds nibbles lo..hi one per cycle after a start pulse.
// sum_o/done_o include the nibble being added this cycle so the caller can capture without an extra cycle.
module serial_range_acc
  import range_sum_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [IDX_W-1:0] lo_i,
  input  logic [IDX_W-1:0] hi_i,
  input  logic [BUS_W-1:0] operands_i,
  output logic             done_o,
  output logic [SUM_W-1:0] sum_o
);

  logic [IDX_W-1:0] idx_q, hi_q;
  logic [SUM_W-1:0] acc_q;
  logic             busy_q, done_q;
  logic [NIB_W-1:0] nib;
  logic             last;

  assign nib  = operands_i[idx_q*NIB_W +: NIB_W];
  assign last = busy_q && (idx_q == hi_q);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      hi_q   <= '0;
      acc_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (start_i) begin
      idx_q  <= lo_i;
      hi_q   <= hi_i;
      acc_q  <= '0;
      busy_q <= 1'b1;
      done_q <= 1'b0;
    end else if (busy_q) begin
      acc_q <= acc_q + zext_nib(nib);
      if (last) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  assign done_o = done_q | last;
  assign sum_o  = busy_q ? acc_q + zext_nib(nib) : acc_q;

endmodule

// File: rtl/range_sum_driver.sv
// Front-end for the combinational range-sum adder: operand registers, query FSM, result capture.
// Optional serial cross-check enabled by defining RANGE_SELFCHECK_EN.
module range_sum_driver
  import range_sum_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              CLK100MHZ,
  input  logic              BTNU,
  range_sum_driver_if.slave bus
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [BUS_W-1:0]   operands_q;
  logic [2*IDX_W-1:0] contr_q;
  logic [SUM_W-1:0]   res_data_q;
  logic               mismatch_q;
  logic               idle, accept, wr_en, capture_en;
  logic               chk_done, chk_mismatch;

  assign idle       = (state_q == IDLE);
  assign accept     = idle && bus.q_valid;
  assign wr_en      = idle && bus.wr_valid;
  assign capture_en = (state_q == SETTLE) && (state_d == CAPTURE);

`ifdef RANGE_SELFCHECK_EN
  logic [IDX_W-1:0] rng_lo, rng_hi;
  logic [SUM_W-1:0] chk_sum;

  assign rng_lo = (bus.q_hi < bus.q_lo) ? bus.q_hi : bus.q_lo;
  assign rng_hi = (bus.q_hi < bus.q_lo) ? bus.q_lo : bus.q_hi;

  serial_range_acc u_acc (
    .clk        (CLK100MHZ),
    .rst        (BTNU),
    .start_i    (accept),
    .lo_i       (rng_lo),
    .hi_i       (rng_hi),
    .operands_i (operands_q),
    .done_o     (chk_done),
    .sum_o      (chk_sum)
  );

  assign chk_mismatch = (bus.sum_in != chk_sum);
`else
  assign chk_done     = 1'b1;
  assign chk_mismatch = 1'b0;
`endif

  // NOTE: the operand file is only 32 flops and must read back as zero after reset, so it is reset like any other register.
  always_ff @(posedge CLK100MHZ or posedge BTNU) begin
    if (BTNU) begin
      operands_q <= '0;
    end else if (wr_en) begin
      operands_q[bus.wr_addr*NIB_W +: NIB_W] <= bus.wr_data;
    end
  end

  always_ff @(posedge CLK100MHZ or posedge BTNU) begin
    if (BTNU) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      contr_q    <= '0;
      res_data_q <= '0;
      mismatch_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) contr_q <= {bus.q_hi, bus.q_lo};
      if (capture_en) begin
        res_data_q <= bus.sum_in;
        mismatch_q <= chk_mismatch;
      end
    end
  end

  // NOTE: next-state signals get defaults before the case so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.q_valid) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        // Counter saturates so a slow checker cannot wrap it past the settle target.
        if (cnt_q != SETTLE_LAST) cnt_d = cnt_q + 4'd1;
        if ((cnt_q == SETTLE_LAST) && chk_done) state_d = CAPTURE;
      end
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.wr_ready  = idle;
  assign bus.q_ready   = idle;
  assign bus.clr_out   = idle;
  assign bus.I_out     = operands_q;
  assign bus.contr_out = contr_q;
  assign bus.res_valid = (state_q == CAPTURE);
  assign bus.res_data  = res_data_q;
  assign bus.mismatch  = mismatch_q;

endmodule

// File: tb/tb_range_sum_driver.sv
// Self-checking bench for range_sum_driver: stub adder, array reference model, randomized queries.
module tb_range_sum_driver;
  import range_sum_pkg::*;

  localparam int S = 2;

  logic clk = 1'b0;
  logic rst;
  int   bias = 0;
  int   mem [NUM_NIB];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  range_sum_driver_if bus ();

  range_sum_driver #(.SETTLE_CYCLES(S)) dut (
    .CLK100MHZ (clk),
    .BTNU      (rst),
    .bus       (bus)
  );

  // Stub adder: true range sum of the driven bus plus an injectable error.
  function automatic logic [SUM_W-1:0] adder_stub(input logic [BUS_W-1:0] ops,
                                                  input logic [5:0] contr, input int err);
    int a, b, s;
    a = int'(contr[5:3]);
    b = int'(contr[2:0]);
    s = err;
    for (int k = 0; k < NUM_NIB; k++)
      if (k >= (a < b ? a : b) && k <= (a < b ? b : a)) s += int'(ops[k*4 +: 4]);
    return SUM_W'(s);
  endfunction

  assign bus.sum_in = bus.clr_out ? '0 : adder_stub(bus.I_out, bus.contr_out, bias);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_sum(input int a, input int b);
    int s = 0;
    for (int k = (a < b ? a : b); k <= (a < b ? b : a); k++) s += mem[k];
    return s;
  endfunction

  function automatic int ref_latency(input int a, input int b);
    int span = (a < b ? b - a : a - b) + 1;
`ifdef RANGE_SELFCHECK_EN
    return (span > S ? span : S) + 1;
`else
    span = 0;
    return S + 1 + span;
`endif
  endfunction

  function automatic logic [31:0] ref_bus();
    logic [31:0] v = '0;
    for (int k = 0; k < NUM_NIB; k++) v[k*4 +: 4] = 4'(mem[k]);
    return v;
  endfunction

  task automatic write_nib(input int a, input int d);
    @(negedge clk);
    check("wr_ready idle", bus.wr_ready, 1);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 3'(a);
    bus.wr_data  = 4'(d);
    @(posedge clk);
    mem[a] = d;
    #1 bus.wr_valid = 1'b0;
  endtask

  // Issues one query; optional same-cycle write and optional blocked write during SETTLE.
  task automatic run_query(input string tag, input int hi, input int lo,
                           input bit with_wr, input int wa, input int wd, input bit settle_wr);
    int cyc = 0;
    bit seen = 0;
    int exp_sum, exp_mm;
    logic [31:0] bus_before;
    @(negedge clk);
    for (int i = 0; i < 20 && !bus.q_ready; i++) @(negedge clk);
    check({tag, " q_ready"}, bus.q_ready, 1);
    bus.q_valid = 1'b1;
    bus.q_hi    = 3'(hi);
    bus.q_lo    = 3'(lo);
    if (with_wr) begin
      bus.wr_valid = 1'b1;
      bus.wr_addr  = 3'(wa);
      bus.wr_data  = 4'(wd);
    end
    @(posedge clk);
    if (with_wr) mem[wa] = wd;
    #1;
    bus.q_valid  = 1'b0;
    bus.wr_valid = 1'b0;
    bus_before = ref_bus();
    exp_sum = (ref_sum(hi, lo) + bias) & 8'hFF;
`ifdef RANGE_SELFCHECK_EN
    exp_mm = (bias != 0) ? 1 : 0;
`else
    exp_mm = 0;
`endif
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check({tag, " contr"}, bus.contr_out, {hi[2:0], lo[2:0]});
        check({tag, " clr busy"}, bus.clr_out, 0);
        check({tag, " wr_ready busy"}, bus.wr_ready, 0);
        if (settle_wr) begin
          bus.wr_valid = 1'b1;
          bus.wr_addr  = 3'(wa);
          bus.wr_data  = 4'(wd);
        end
      end
      if (bus.res_valid) begin
        seen = 1;
        cyc  = c;
        bus.wr_valid = 1'b0;
      end
    end
    bus.wr_valid = 1'b0;
    check({tag, " latency"}, cyc, ref_latency(hi, lo));
    if (seen) begin
      check({tag, " res_data"}, bus.res_data, exp_sum);
      check({tag, " mismatch"}, bus.mismatch, exp_mm);
      @(negedge clk);
      check({tag, " strobe 1cyc"}, bus.res_valid, 0);
      check({tag, " res held"}, bus.res_data, exp_sum);
      check({tag, " q_ready back"}, bus.q_ready, 1);
      check({tag, " clr back"}, bus.clr_out, 1);
      if (settle_wr) check({tag, " operands kept"}, bus.I_out, bus_before);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit rv_seen;
    rst = 1'b1;
    bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.q_valid  = 1'b0; bus.q_hi = '0; bus.q_lo = '0;
    for (int k = 0; k < NUM_NIB; k++) mem[k] = 0;
    repeat (2) @(negedge clk);
    check("rst I_out", bus.I_out, 0);
    check("rst contr", bus.contr_out, 0);
    check("rst clr", bus.clr_out, 1);
    check("rst res_valid", bus.res_valid, 0);
    check("rst res_data", bus.res_data, 0);
    check("rst mismatch", bus.mismatch, 0);
    check("rst ready", {bus.wr_ready, bus.q_ready}, 2'b11);
    rst = 1'b0;

    for (int k = 0; k < NUM_NIB; k++) write_nib(k, k + 1);
    @(negedge clk);
    check("I_out 1..8", bus.I_out, 32'h8765_4321);

    run_query("q2_5", 2, 5, 0, 0, 0, 0);
    run_query("q6_1", 6, 1, 0, 0, 0, 0);
    run_query("q7_7", 7, 7, 0, 0, 0, 0);
    bias = 1;
    run_query("stub+1", 3, 0, 0, 0, 0, 0);
    bias = 0;
    run_query("settle wr", 0, 7, 0, 0, 9, 1);
    run_query("wr+query", 4, 4, 1, 4, 12, 0);
    for (int k = 0; k < NUM_NIB; k++) write_nib(k, 15);
    run_query("all15", 0, 7, 0, 0, 0, 0);

    for (int n = 0; n < 25; n++) begin
      int nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++) write_nib($urandom_range(0, 7), $urandom_range(0, 15));
      bias = ($urandom_range(0, 4) == 0) ? 1 : 0;
      run_query("rand", $urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 15), 0);
    end
    bias = 0;

    // Reset during cycle 1 of a query.
    @(negedge clk);
    bus.q_valid = 1'b1; bus.q_hi = 3'd0; bus.q_lo = 3'd7;
    @(posedge clk);
    #1 bus.q_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < NUM_NIB; k++) mem[k] = 0;
    #1;
    check("mid rst res_valid", bus.res_valid, 0);
    check("mid rst I_out", bus.I_out, 0);
    check("mid rst contr", bus.contr_out, 0);
    check("mid rst clr", bus.clr_out, 1);
    check("mid rst res_data", bus.res_data, 0);
    check("mid rst mismatch", bus.mismatch, 0);
    @(negedge clk);
    rst = 1'b0;
    rv_seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.res_valid) rv_seen = 1;
    end
    check("mid rst no strobe", rv_seen, 0);
    check("mid rst q_ready", bus.q_ready, 1);
    run_query("post rst", 1, 6, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
